// File: rtl/intt_stream_ctrl_pkg.sv
// Shared types and constants for the INTT streaming wrapper.
// Holds coefficient/address widths, modulus and FSM state encoding.
package intt_stream_ctrl_pkg;

  localparam int N_COEF = 256;
  localparam int Q      = 8380417;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] coef_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_UNLOAD,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/intt_stream_ctrl_if.sv
// Stream, memory-port and transform-control bundle of the INTT wrapper.
// master is the controller side, slave the environment side.
interface intt_stream_ctrl_if;
  import intt_stream_ctrl_pkg::*;

  logic  s_valid;
  coef_t s_data;
  logic  s_ready;
  logic  m_valid;
  coef_t m_data;
  logic  m_ready;
  logic  load_mem;
  addr_t A_load;
  coef_t D_load;
  logic  WEB_load;
  logic  start_NTT;
  logic  done_NTT;
  coef_t Q0;
  logic  busy;

  modport master (
    input  s_valid, s_data, m_ready,
    input  done_NTT, Q0,
    output s_ready, m_valid, m_data,
    output load_mem, A_load, D_load,
    output WEB_load, start_NTT, busy
  );

  modport slave (
    output s_valid, s_data, m_ready,
    output done_NTT, Q0,
    input  s_ready, m_valid, m_data,
    input  load_mem, A_load, D_load,
    input  WEB_load, start_NTT, busy
  );

endinterface

// File: rtl/intt_stream_ctrl_coef_skid_fifo.sv
// Two-entry coefficient FIFO between memory read data and the output stream.
// Accepts a push while full if the head is popped in the same cycle.
module coef_skid_fifo
  import intt_stream_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  coef_t      din,
  input  logic       pop,
  output coef_t      dout,
  output logic       valid,
  output logic [1:0] count
);

  coef_t e0, e1;
  logic  wp, rp;
  logic  do_push, do_pop;

  assign valid   = count != 2'd0;
  assign do_pop  = pop & valid;
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign dout    = !valid ? '0 : (rp ? e1 : e0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        if (wp) e1 <= din;
        else    e0 <= din;
        wp <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/intt_stream_ctrl.sv
// Streams a polynomial into memory, kicks the INTT, then streams it out.
// Read issue is throttled so the 2-entry FIFO can never overflow.
module intt_stream_ctrl
  import intt_stream_ctrl_pkg::*;
#(
  parameter int    N_COEF    = intt_stream_ctrl_pkg::N_COEF,
  parameter addr_t BASE_ADDR = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  intt_stream_ctrl_if.master bus
);

  localparam addr_t LAST = addr_t'(N_COEF - 1);

  state_t     state, state_nx;
  addr_t      idx, ridx;
  logic       inflight;
  logic       accept, issue, pop;
  logic       in_last, rd_last;
  logic       fifo_valid;
  logic [1:0] occ;
  logic [2:0] fill;
  coef_t      fifo_dout;

  logic  load_mem, web, start;
  addr_t a_load;
  coef_t d_load;

  assign in_last = idx == LAST;
  assign rd_last = ridx == LAST;
  assign pop     = fifo_valid & bus.m_ready;

  assign accept = rst_n & bus.s_valid
                & (state == S_IDLE
                 | state == S_LOAD);

  // Credit check counts this cycle's pop so
  // reads can stream back to back.
  assign fill  = {1'b0, occ}
               + {2'b00, inflight}
               - {2'b00, pop};
  assign issue = (state == S_UNLOAD)
               && (fill < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      ridx     <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (accept)
        idx <= in_last ? '0 : idx + 1'b1;
      if (issue)
        ridx <= rd_last ? '0 : ridx + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    load_mem = 1'b0;
    web      = 1'b1;
    start    = 1'b0;
    a_load   = '0;
    d_load   = '0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          load_mem = 1'b1;
          web      = 1'b0;
          a_load   = BASE_ADDR + idx;
          d_load   = bus.s_data;
          state_nx = in_last ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        load_mem = 1'b1;
        a_load   = BASE_ADDR + idx;
        if (accept) begin
          web    = 1'b0;
          d_load = bus.s_data;
          if (in_last) state_nx = S_START;
        end
      end
      S_START: begin
        start    = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.done_NTT) state_nx = S_UNLOAD;
      end
      S_UNLOAD: begin
        load_mem = 1'b1;
        a_load   = BASE_ADDR + ridx;
        if (issue && rd_last)
          state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        load_mem = 1'b1;
        if (!fifo_valid && !inflight)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  coef_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (bus.Q0),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (occ)
  );

  assign bus.s_ready   = rst_n
                       & (state == S_IDLE
                        | state == S_LOAD);
  assign bus.m_valid   = fifo_valid;
  assign bus.m_data    = fifo_dout;
  assign bus.load_mem  = load_mem;
  assign bus.A_load    = a_load;
  assign bus.D_load    = d_load;
  assign bus.WEB_load  = web;
  assign bus.start_NTT = start;
  assign bus.busy      = state != S_IDLE;

endmodule

// File: tb/tb_intt_stream_ctrl.sv
// Directed bench for intt_stream_ctrl: table of full flows plus corner cases.
// Two DUTs share stimulus; the second sits at a wrapping base address.
module tb_intt_stream_ctrl;
  import intt_stream_ctrl_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  s_valid;
  coef_t s_data;
  logic  m_ready;
  logic  done_model;
  logic  done_early;

  always #5 clk = ~clk;

  intt_stream_ctrl_if b1 ();
  intt_stream_ctrl_if b2 ();

  assign b1.s_valid  = s_valid;
  assign b1.s_data   = s_data;
  assign b1.m_ready  = m_ready;
  assign b1.done_NTT = done_model | done_early;
  assign b2.s_valid  = s_valid;
  assign b2.s_data   = s_data;
  assign b2.m_ready  = m_ready;
  assign b2.done_NTT = done_model | done_early;

  intt_stream_ctrl #(
    .N_COEF(256), .BASE_ADDR(16'h0000)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  intt_stream_ctrl #(
    .N_COEF(256), .BASE_ADDR(16'hFFF0)
  ) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // memory models: registered read, one cycle latency
  coef_t mem1 [0:65535];
  coef_t mem2 [0:65535];
  coef_t q1, q2;
  always @(posedge clk) begin
    if (b1.load_mem && !b1.WEB_load)
      mem1[b1.A_load] <= b1.D_load;
    if (b2.load_mem && !b2.WEB_load)
      mem2[b2.A_load] <= b2.D_load;
    q1 <= mem1[b1.A_load];
    q2 <= mem2[b2.A_load];
  end
  assign b1.Q0 = q1;
  assign b2.Q0 = q2;

  // INTT model: done one cycle, 50 cycles after start
  initial begin
    done_model = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && b1.start_NTT) begin
        repeat (50) @(posedge clk);
        #1 done_model = 1'b1;
        @(posedge clk);
        #1 done_model = 1'b0;
      end
    end
  end

  coef_t stim [256];
  int cyc, wr_idx, wr_err, out_idx, out_err;
  int starts, start_at, first_out, last_out;
  int wr2_idx, wr2_err, out2_idx, out2_err;
  logic [15:0] last_a2;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      wr_idx = 0; wr_err = 0;
      out_idx = 0; out_err = 0;
      starts = 0; start_at = -1;
      first_out = 0; last_out = 0;
      wr2_idx = 0; wr2_err = 0;
      out2_idx = 0; out2_err = 0;
      last_a2 = 16'h0;
    end else begin
      if (b1.load_mem && !b1.WEB_load) begin
        if (!(b1.s_valid && b1.s_ready)
            || b1.A_load != 16'(wr_idx)
            || b1.D_load != stim[wr_idx % 256])
          wr_err++;
        wr_idx++;
      end else if (b1.s_valid && b1.s_ready)
        wr_err++;
      if (b1.start_NTT) begin
        starts++;
        start_at = wr_idx;
      end
      if (b1.m_valid && b1.m_ready) begin
        if (b1.m_data != stim[out_idx % 256])
          out_err++;
        if (out_idx == 0) first_out = cyc;
        last_out = cyc;
        out_idx++;
      end
      if (b2.load_mem && !b2.WEB_load) begin
        if (b2.A_load != 16'hFFF0 + 16'(wr2_idx)
            || b2.D_load != stim[wr2_idx % 256])
          wr2_err++;
        last_a2 = b2.A_load;
        wr2_idx++;
      end
      if (b2.m_valid && b2.m_ready) begin
        if (b2.m_data != stim[out2_idx % 256])
          out2_err++;
        out2_idx++;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_flow(input int gap,
                          input int bp,
                          input int mult,
                          input int off,
                          input bit early,
                          input int stop);
    for (int k = 0; k < 256; k++)
      stim[k] = coef_t'((k * mult + off) % Q);
    do_reset();
    fork
      begin
        int k = 0;
        int c = 0;
        while (k < 256 && c < 5000) begin
          s_valid = (gap == 0) || (c % 2 == 0);
          s_data  = s_valid ? stim[k] : 24'hABCDEF;
          done_early = early && k == 100;
          @(negedge clk);
          if (s_valid && b1.s_ready) k++;
          @(posedge clk);
          #1 c++;
        end
        s_valid    = 1'b0;
        s_data     = '0;
        done_early = 1'b0;
      end
      begin
        int c = 0;
        while (out_idx < stop && c < 20000) begin
          m_ready = (bp == 0)
                  || ($urandom_range(0, 99) < bp);
          @(posedge clk);
          #1 c++;
        end
        m_ready = 1'b1;
      end
    join
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && b1.busy; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "/idle"}, int'(b1.busy), 0);
  endtask

  typedef struct {
    string name;
    int    gap;
    int    bp;
    int    mult;
    int    off;
    bit    early;
    int    exp_wr;
    int    exp_st;
    int    exp_out;
    int    exp_span;
    int    exp_a2;
  } vec_t;

  vec_t vec [5];

  initial begin
    vec[0] = '{"full",  0,  0,    1,       0,
               1'b0, 256, 1, 256, 255, 16'h00EF};
    vec[1] = '{"gaps",  1,  0,  997,       5,
               1'b0, 256, 1, 256, 255, 16'h00EF};
    vec[2] = '{"bp30",  0, 30,    1,       0,
               1'b0, 256, 1, 256,  -1, 16'h00EF};
    vec[3] = '{"early", 0,  0, 4093, 8380000,
               1'b1, 256, 1, 256, 255, 16'h00EF};
    vec[4] = '{"mix",   1, 30,   31,      77,
               1'b0, 256, 1, 256,  -1, 16'h00EF};

    done_early = 1'b0;
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 24'h123456;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst/s_ready",   int'(b1.s_ready),   0);
    check("rst/m_valid",   int'(b1.m_valid),   0);
    check("rst/m_data",    int'(b1.m_data),    0);
    check("rst/load_mem",  int'(b1.load_mem),  0);
    check("rst/A_load",    int'(b1.A_load),    0);
    check("rst/D_load",    int'(b1.D_load),    0);
    check("rst/WEB_load",  int'(b1.WEB_load),  1);
    check("rst/start_NTT", int'(b1.start_NTT), 0);
    check("rst/busy",      int'(b1.busy),      0);

    for (int v = 0; v < 5; v++) begin
      run_flow(vec[v].gap, vec[v].bp,
               vec[v].mult, vec[v].off,
               vec[v].early, 256);
      wait_idle(vec[v].name);
      check({vec[v].name, "/writes"},
            wr_idx, vec[v].exp_wr);
      check({vec[v].name, "/wr_err"}, wr_err, 0);
      check({vec[v].name, "/starts"},
            starts, vec[v].exp_st);
      check({vec[v].name, "/start_at"},
            start_at, vec[v].exp_wr);
      check({vec[v].name, "/outputs"},
            out_idx, vec[v].exp_out);
      check({vec[v].name, "/out_err"}, out_err, 0);
      if (vec[v].exp_span >= 0)
        check({vec[v].name, "/span"},
              last_out - first_out,
              vec[v].exp_span);
      check({vec[v].name, "/wrap_last"},
            int'(last_a2), vec[v].exp_a2);
      check({vec[v].name, "/dut2_err"},
            wr2_err + out2_err, 0);
      check({vec[v].name, "/dut2_out"},
            out2_idx, vec[v].exp_out);
    end

    // stall in LOAD with a spurious done
    for (int k = 0; k < 256; k++)
      stim[k] = coef_t'(k + 40);
    do_reset();
    s_valid = 1'b1;
    s_data  = stim[0];
    @(posedge clk);
    #1 s_valid = 1'b0;
    s_data     = 24'h555555;
    done_early = 1'b1;
    @(negedge clk);
    check("stall/WEB_load", int'(b1.WEB_load), 1);
    check("stall/s_ready",  int'(b1.s_ready),  1);
    check("stall/busy",     int'(b1.busy),     1);
    @(posedge clk);
    #1 done_early = 1'b0;
    @(negedge clk);
    check("stall/start",   int'(b1.start_NTT), 0);
    check("stall/s_ready2", int'(b1.s_ready),  1);
    check("stall/wr_idx",  wr_idx, 1);
    check("stall/wr_err",  wr_err, 0);

    // reset while unloading, at output 100
    run_flow(0, 0, 3, 11, 1'b0, 100);
    check("rstu/out_at", out_idx, 100);
    rst_n = 1'b0;
    #1;
    check("rstu/busy",     int'(b1.busy),     0);
    check("rstu/m_valid",  int'(b1.m_valid),  0);
    check("rstu/WEB_load", int'(b1.WEB_load), 1);
    check("rstu/load_mem", int'(b1.load_mem), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_flow(0, 0, 5, 2, 1'b0, 256);
    wait_idle("again");
    check("again/writes",  wr_idx, 256);
    check("again/starts",  starts, 1);
    check("again/outputs", out_idx, 256);
    check("again/out_err", out_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
